lock_ctrl_param: RTL and testbench

//  Parametrised doorlock control FSM. Sits between the keypad/button front end and the password
//  mem/buffer shift registers. Sequences set/confirm/challenge, counts digits internally,

---
 rtl/lock_ctrl_param.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_lock_ctrl_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl_param.sv
// lock_ctrl_param: parametrised door-lock sequencing FSM.
// Drives the password memory / entry buffer shift registers while sequencing
// set -> confirm -> lock -> challenge. It counts entered digits, times the
// shuffle, long-press and lockout windows, and locks out after MAX_ERR
// consecutive challenge failures (only the master password is accepted then).
// Optional feature macro: AUTO_RELOCK_EN. When defined, UNLK relocks itself
// after AUTO_LOCK_CYC idle cycles, and the confirm hold time is measured by a
// separate counter.
module lock_ctrl_param #(
    parameter int PSW_MAX_LEN    = 8,
    parameter int MAX_ERR        = 5,
    parameter int LONG_PRESS_CYC = 10,
    parameter int SHUFFLE_CYC    = 10,
    parameter int LOCKOUT_CYC    = 100,
    parameter int AUTO_LOCK_CYC  = 1000,
    parameter int CNT_W          = 32,
    localparam int DW            = $clog2(PSW_MAX_LEN + 1),
    localparam int EW            = $clog2(MAX_ERR + 1)
) (
    input  logic          clk,
    input  logic          nreset_i,
    input  logic          confirm_i,
    input  logic          shuffle_i,
    input  logic          digit_valid_i,
    input  logic          match_i,
    input  logic          master_match_i,
    output logic [2:0]    state_o,
    output logic [EW-1:0] err_cnt_o,
    output logic          shuffle_init_o,
    output logic          mem_rst_o,
    output logic          mem_sl_o,
    output logic          buff_rst_o,
    output logic          buff_sl_o,
    output logic          unlocked_o,
    output logic          lockout_o
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_SET  = 3'd1,
        ST_CONF = 3'd2,
        ST_CHAL = 3'd3,
        ST_SHUF = 3'd4,
        ST_LOCK = 3'd5,
        ST_UNLK = 3'd6,
        ST_LOUT = 3'd7
    } state_t;

    localparam logic [DW-1:0]    DIG_MAX    = DW'(PSW_MAX_LEN);
    localparam logic [EW-1:0]    ERR_MAX    = EW'(MAX_ERR);
    localparam logic [CNT_W-1:0] SHUF_LAST  = CNT_W'(SHUFFLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOUT_LAST  = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_PRESS = CNT_W'(LONG_PRESS_CYC);
`ifdef AUTO_RELOCK_EN
    localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(AUTO_LOCK_CYC - 1);
`endif

    // Reject parameter sets that would make the timers or counters meaningless.
    if (PSW_MAX_LEN < 1 || MAX_ERR < 1 || SHUFFLE_CYC < 1 || LOCKOUT_CYC < 1 ||
        AUTO_LOCK_CYC < 1 || LONG_PRESS_CYC < 0 || CNT_W < 2) begin : g_param_check
        $error("lock_ctrl_param: invalid parameter set");
    end

    // Saturating increment for the cycle counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Failure count increment, clamped at MAX_ERR.
    function automatic logic [EW-1:0] err_inc(input logic [EW-1:0] e);
        return (e >= ERR_MAX) ? ERR_MAX : e + EW'(1);
    endfunction

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [EW-1:0]    err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
`ifdef AUTO_RELOCK_EN
    logic [CNT_W-1:0] hold_q, hold_d;
`endif
    logic             conf_prev_q, shuf_prev_q;
    logic             shuffle_init_q, shuffle_init_d;
    logic             mem_rst_q, mem_rst_d;
    logic             mem_sl_q, mem_sl_d;
    logic             buff_rst_q, buff_rst_d;
    logic             buff_sl_q, buff_sl_d;

    logic             conf_rel, shuf_rel, chal_fail;
    logic [CNT_W-1:0] press_len;

    // A release is a falling level seen between the previous and current sample.
    assign conf_rel = conf_prev_q & ~confirm_i;
    assign shuf_rel = shuf_prev_q & ~shuffle_i;

`ifdef AUTO_RELOCK_EN
    assign press_len = hold_q;
`else
    assign press_len = cyc_q;
`endif

    // Next-state, counter and command-pulse logic.
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        dcnt_d         = dcnt_q;
        err_d          = err_q;
        cyc_d          = sat_inc(cyc_q);
`ifdef AUTO_RELOCK_EN
        hold_d         = hold_q;
`endif
        shuffle_init_d = 1'b0;
        mem_rst_d      = 1'b0;
        mem_sl_d       = 1'b0;
        buff_rst_d     = 1'b0;
        buff_sl_d      = 1'b0;
        chal_fail      = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d    = ST_SET;
                mem_rst_d  = 1'b1;
                buff_rst_d = 1'b1;
                dcnt_d     = '0;
            end

            ST_SET, ST_CONF, ST_CHAL: begin
                if (shuf_rel) begin
                    // Digit count and error count survive the shuffle.
                    ret_d          = state_q;
                    state_d        = ST_SHUF;
                    shuffle_init_d = 1'b1;
                end else if (conf_rel) begin
                    case (state_q)
                        ST_SET: begin
                            if (dcnt_q != '0) begin
                                state_d    = ST_CONF;
                                buff_rst_d = 1'b1;
                                dcnt_d     = '0;
                            end
                        end
                        ST_CONF: begin
                            dcnt_d = '0;
                            if (match_i) begin
                                state_d = ST_LOCK;
                            end else begin
                                state_d   = ST_SET;
                                mem_rst_d = 1'b1;
                            end
                        end
                        default: begin
                            // Once locked out, only the master password opens.
                            if ((match_i && (err_q < ERR_MAX)) || master_match_i) begin
                                state_d = ST_UNLK;
                                err_d   = '0;
                                dcnt_d  = '0;
                            end else begin
                                chal_fail = 1'b1;
                            end
                        end
                    endcase
                end else if (digit_valid_i) begin
                    if (dcnt_q < DIG_MAX) begin
                        dcnt_d = dcnt_q + DW'(1);
                        if (state_q == ST_SET) begin
                            mem_sl_d = 1'b1;
                        end else begin
                            buff_sl_d = 1'b1;
                        end
                    end else begin
                        case (state_q)
                            ST_SET: begin
                                mem_rst_d = 1'b1;
                                dcnt_d    = '0;
                            end
                            ST_CONF: begin
                                state_d    = ST_SET;
                                mem_rst_d  = 1'b1;
                                buff_rst_d = 1'b1;
                                dcnt_d     = '0;
                            end
                            default: begin
                                chal_fail = 1'b1;
                            end
                        endcase
                    end
                end

                if (chal_fail) begin
                    err_d   = err_inc(err_q);
                    dcnt_d  = '0;
                    state_d = (err_inc(err_q) == ERR_MAX) ? ST_LOUT : ST_LOCK;
                end
            end

            ST_SHUF: begin
                if (cyc_q >= SHUF_LAST) begin
                    state_d = ret_q;
                end
            end

            ST_LOCK: begin
                if (conf_rel) begin
                    state_d    = ST_CHAL;
                    buff_rst_d = 1'b1;
                    dcnt_d     = '0;
                end
            end

            ST_UNLK: begin
`ifdef AUTO_RELOCK_EN
                hold_d = confirm_i ? sat_inc(hold_q) : hold_q;
                cyc_d  = confirm_i ? '0 : sat_inc(cyc_q);
`else
                cyc_d  = confirm_i ? sat_inc(cyc_q) : cyc_q;
`endif
                if (conf_rel) begin
                    if (press_len >= LONG_PRESS) begin
                        state_d    = ST_SET;
                        mem_rst_d  = 1'b1;
                        buff_rst_d = 1'b1;
                        dcnt_d     = '0;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
`ifdef AUTO_RELOCK_EN
                else if (!confirm_i && (cyc_q >= AUTO_LAST)) begin
                    state_d = ST_LOCK;
                end
`endif
            end

            default: begin
                // ST_LOUT: every input is ignored until the window expires.
                if (cyc_q >= LOUT_LAST) begin
                    state_d = ST_LOCK;
                end
            end
        endcase

        // Every state entry starts its timers from zero.
        if (state_d != state_q) begin
            cyc_d = '0;
`ifdef AUTO_RELOCK_EN
            hold_d = '0;
`endif
        end
    end

    // State, counters, button history and registered command pulses.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q        <= ST_INIT;
            ret_q          <= ST_SET;
            dcnt_q         <= '0;
            err_q          <= '0;
            cyc_q          <= '0;
`ifdef AUTO_RELOCK_EN
            hold_q         <= '0;
`endif
            conf_prev_q    <= 1'b0;
            shuf_prev_q    <= 1'b0;
            shuffle_init_q <= 1'b0;
            mem_rst_q      <= 1'b0;
            mem_sl_q       <= 1'b0;
            buff_rst_q     <= 1'b0;
            buff_sl_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            dcnt_q         <= dcnt_d;
            err_q          <= err_d;
            cyc_q          <= cyc_d;
`ifdef AUTO_RELOCK_EN
            hold_q         <= hold_d;
`endif
            conf_prev_q    <= confirm_i;
            shuf_prev_q    <= shuffle_i;
            shuffle_init_q <= shuffle_init_d;
            mem_rst_q      <= mem_rst_d;
            mem_sl_q       <= mem_sl_d;
            buff_rst_q     <= buff_rst_d;
            buff_sl_q      <= buff_sl_d;
        end
    end

    assign state_o        = state_q;
    assign err_cnt_o      = err_q;
    assign shuffle_init_o = shuffle_init_q;
    assign mem_rst_o      = mem_rst_q;
    assign mem_sl_o       = mem_sl_q;
    assign buff_rst_o     = buff_rst_q;
    assign buff_sl_o      = buff_sl_q;
    assign unlocked_o     = (state_q == ST_UNLK);
    assign lockout_o      = (state_q == ST_LOUT);

endmodule

// File: tb/tb_lock_ctrl_param.sv
// Directed testbench for lock_ctrl_param (PSW_MAX_LEN=4, MAX_ERR=3,
// LONG_PRESS_CYC=10, SHUFFLE_CYC=10, LOCKOUT_CYC=20, AUTO_LOCK_CYC=1000).
// Honours AUTO_RELOCK_EN the same way as the design.
module tb_lock_ctrl_param;

    localparam int S_INIT = 0, S_SET = 1, S_CONF = 2, S_CHAL = 3;
    localparam int S_SHUF = 4, S_LOCK = 5, S_UNLK = 6, S_LOUT = 7;

    logic       clk = 1'b0;
    logic       nreset_i = 1'b0;
    logic       confirm_i = 1'b0;
    logic       shuffle_i = 1'b0;
    logic       digit_valid_i = 1'b0;
    logic       match_i = 1'b0;
    logic       master_match_i = 1'b0;
    logic [2:0] state_o;
    logic [1:0] err_cnt_o;
    logic       shuffle_init_o, mem_rst_o, mem_sl_o, buff_rst_o, buff_sl_o;
    logic       unlocked_o, lockout_o;

    int n_checks = 0;
    int n_errors = 0;

    lock_ctrl_param #(
        .PSW_MAX_LEN   (4),
        .MAX_ERR       (3),
        .LONG_PRESS_CYC(10),
        .SHUFFLE_CYC   (10),
        .LOCKOUT_CYC   (20),
        .AUTO_LOCK_CYC (1000),
        .CNT_W         (32)
    ) dut (
        .clk           (clk),
        .nreset_i      (nreset_i),
        .confirm_i     (confirm_i),
        .shuffle_i     (shuffle_i),
        .digit_valid_i (digit_valid_i),
        .match_i       (match_i),
        .master_match_i(master_match_i),
        .state_o       (state_o),
        .err_cnt_o     (err_cnt_o),
        .shuffle_init_o(shuffle_init_o),
        .mem_rst_o     (mem_rst_o),
        .mem_sl_o      (mem_sl_o),
        .buff_rst_o    (buff_rst_o),
        .buff_sl_o     (buff_sl_o),
        .unlocked_o    (unlocked_o),
        .lockout_o     (lockout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic digit();
        digit_valid_i = 1'b1;
        tick(1);
        digit_valid_i = 1'b0;
    endtask

    task automatic confirm_rel(input int hold, input logic m, input logic mm);
        confirm_i = 1'b1;
        tick(hold);
        confirm_i = 1'b0;
        match_i = m;
        master_match_i = mm;
        tick(1);
        match_i = 1'b0;
        master_match_i = 1'b0;
    endtask

    task automatic shuffle_rel();
        shuffle_i = 1'b1;
        tick(1);
        shuffle_i = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_eq("rst_state", int'(state_o), S_INIT);
        check_eq("rst_err", int'(err_cnt_o), 0);
        check_eq("rst_pulses", int'({shuffle_init_o, mem_rst_o, mem_sl_o, buff_rst_o, buff_sl_o}), 0);
        check_eq("rst_flags", int'({unlocked_o, lockout_o}), 0);
        nreset_i = 1'b1;
        tick(1);
        check_eq("init_to_set", int'(state_o), S_SET);
        check_eq("init_rsts", int'({mem_rst_o, buff_rst_o}), 3);
        tick(1);
        check_eq("init_rst_1cyc", int'({mem_rst_o, buff_rst_o}), 0);

        // Test 1: digits in SET, overflow, empty confirm
        for (int i = 0; i < 4; i++) begin
            digit();
            check_eq("set_mem_sl", int'({mem_sl_o, buff_sl_o}), 2);
        end
        digit();
        check_eq("set_ovf_rst", int'({mem_rst_o, mem_sl_o}), 2);
        check_eq("set_ovf_state", int'(state_o), S_SET);
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("set_empty_conf", int'(state_o), S_SET);
        check_eq("set_empty_brst", int'(buff_rst_o), 0);

        // Test 2: set/confirm mismatch then match
        for (int i = 0; i < 3; i++) digit();
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("to_conf", int'(state_o), S_CONF);
        check_eq("to_conf_brst", int'(buff_rst_o), 1);
        for (int i = 0; i < 3; i++) begin
            digit();
            check_eq("conf_buff_sl", int'({mem_sl_o, buff_sl_o}), 1);
        end
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("conf_nomatch", int'(state_o), S_SET);
        check_eq("conf_nomatch_mrst", int'(mem_rst_o), 1);
        for (int i = 0; i < 3; i++) digit();
        confirm_rel(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) digit();
        confirm_rel(1, 1'b1, 1'b0);
        check_eq("conf_match", int'(state_o), S_LOCK);

        // Test 3: challenge failures, lockout, master override
        for (int e = 1; e <= 3; e++) begin
            confirm_rel(1, 1'b0, 1'b0);
            check_eq("lock_to_chal", int'({state_o, buff_rst_o}), S_CHAL * 2 + 1);
            confirm_rel(1, 1'b0, 1'b0);
            check_eq("chal_fail_err", int'(err_cnt_o), e);
            check_eq("chal_fail_state", int'(state_o), (e < 3) ? S_LOCK : S_LOUT);
        end
        check_eq("lockout_flag", int'(lockout_o), 1);
        confirm_i = 1'b1;
        tick(5);
        confirm_i = 1'b0;
        tick(14);
        check_eq("lout_hold", int'(state_o), S_LOUT);
        tick(1);
        check_eq("lout_expire", int'(state_o), S_LOCK);
        check_eq("lout_err_held", int'(err_cnt_o), 3);
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b1, 1'b0);
        check_eq("maxerr_match_fails", int'(state_o), S_LOUT);
        check_eq("maxerr_err", int'(err_cnt_o), 3);
        tick(20);
        check_eq("lout_expire2", int'(state_o), S_LOCK);
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b0, 1'b1);
        check_eq("master_unlk", int'(state_o), S_UNLK);
        check_eq("master_err_clr", int'(err_cnt_o), 0);
        check_eq("unlocked_flag", int'(unlocked_o), 1);

        // Test 4: short and long presses in UNLK
        confirm_rel(3, 1'b0, 1'b0);
        check_eq("unlk_short", int'(state_o), S_LOCK);
        check_eq("unlk_short_mrst", int'(mem_rst_o), 0);
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b1, 1'b0);
        check_eq("reunlk", int'(state_o), S_UNLK);
        confirm_rel(9, 1'b0, 1'b0);
        check_eq("unlk_hold9", int'(state_o), S_LOCK);
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b1, 1'b0);
        confirm_rel(10, 1'b0, 1'b0);
        check_eq("unlk_hold10", int'(state_o), S_SET);
        check_eq("unlk_hold10_rsts", int'({mem_rst_o, buff_rst_o}), 3);

        // Test 5: shuffle from CONF preserves digit count; shuffle beats confirm
        digit();
        digit();
        confirm_rel(1, 1'b0, 1'b0);
        digit();
        digit();
        shuffle_rel();
        check_eq("shuf_entry", int'(state_o), S_SHUF);
        check_eq("shuf_init", int'(shuffle_init_o), 1);
        tick(1);
        check_eq("shuf_init_1cyc", int'(shuffle_init_o), 0);
        digit();
        check_eq("shuf_digit_ign", int'(buff_sl_o), 0);
        tick(7);
        check_eq("shuf_hold", int'(state_o), S_SHUF);
        tick(1);
        check_eq("shuf_return", int'(state_o), S_CONF);
        digit();
        check_eq("post_shuf_d3", int'(buff_sl_o), 1);
        digit();
        check_eq("post_shuf_d4", int'(buff_sl_o), 1);
        digit();
        check_eq("conf_ovf", int'({state_o, mem_rst_o, buff_rst_o}), S_SET * 4 + 3);
        digit();
        confirm_i = 1'b1;
        shuffle_i = 1'b1;
        tick(1);
        confirm_i = 1'b0;
        shuffle_i = 1'b0;
        tick(1);
        check_eq("shuf_priority", int'(state_o), S_SHUF);
        check_eq("shuf_prio_brst", int'(buff_rst_o), 0);
        tick(10);
        check_eq("shuf_back_set", int'(state_o), S_SET);
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("set_cnt_kept", int'(state_o), S_CONF);

        // Test 6: UNLK idle behaviour
        confirm_rel(1, 1'b1, 1'b0);
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b0, 1'b1);
        check_eq("unlk6", int'(state_o), S_UNLK);
`ifdef AUTO_RELOCK_EN
        tick(999);
        check_eq("auto_hold", int'(state_o), S_UNLK);
        tick(1);
        check_eq("auto_lock", int'(state_o), S_LOCK);
        check_eq("auto_lock_cmds", int'({mem_rst_o, buff_rst_o}), 0);
`else
        tick(2000);
        check_eq("no_auto_lock", int'(state_o), S_UNLK);
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("unlk_to_lock", int'(state_o), S_LOCK);
`endif

        // Async reset mid-operation with a pulse pending
        confirm_rel(1, 1'b0, 1'b0);
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("pre_rst_err", int'(err_cnt_o), 1);
        confirm_rel(1, 1'b0, 1'b0);
        check_eq("pre_rst_brst", int'(buff_rst_o), 1);
        #1 nreset_i = 1'b0;
        #1;
        check_eq("arst_state", int'(state_o), S_INIT);
        check_eq("arst_err", int'(err_cnt_o), 0);
        check_eq("arst_pulses", int'({shuffle_init_o, mem_rst_o, mem_sl_o, buff_rst_o, buff_sl_o}), 0);
        tick(1);
        nreset_i = 1'b1;
        tick(1);
        check_eq("arst_recover", int'({state_o, mem_rst_o, buff_rst_o}), S_SET * 4 + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
